fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: the state encoding,
// the opcode that marks a two-byte instruction, and the fixed vector addresses.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RST_VEC   = 2'd0,
    ST_FETCH_OP  = 2'd1,
    ST_FETCH_IMM = 2'd2,
    ST_INTR_VEC  = 2'd3
  } fetch_state_e;

  localparam logic [3:0] OPC_TWO_BYTE   = 4'hC;
  localparam logic [7:0] RESET_VEC_ADDR = 8'h00;
  localparam logic [7:0] INTR_VEC_ADDR  = 8'h01;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads one byte per cycle from an asynchronous
// instruction memory and issues one- and two-byte instructions to the decoder.
// Optional interrupt entry is enabled by defining the macro FETCH_INTR_EN.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  input  logic       stall,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  input  logic       intr_req,
  output logic [7:0] if_instr,
  output logic [7:0] if_imm,
  output logic [7:0] if_pc_next,
  output logic       if_valid,
  output logic       if_intr
);

  fetch_state_e state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [7:0]   op_hold_q, op_hold_d;
  logic [7:0]   if_instr_q, if_instr_d;
  logic [7:0]   if_imm_q, if_imm_d;
  logic [7:0]   if_pc_next_q, if_pc_next_d;
  logic         if_valid_q, if_valid_d;
  logic [7:0]   pc_inc;
  logic         intr_pending_eff;

`ifdef FETCH_INTR_EN
  logic         intr_pending_q, intr_pending_d;
  logic         if_intr_q, if_intr_d;
  logic         intr_enter;

  // A request arriving this cycle is honoured immediately at a boundary.
  assign intr_pending_eff = intr_pending_q | intr_req;
  assign if_intr          = if_intr_q;
`else
  logic         unused_intr_req;

  assign unused_intr_req  = intr_req;
  assign intr_pending_eff = 1'b0;
  assign if_intr          = 1'b0;
`endif

  assign pc_inc     = pc_q + 8'd1;
  assign if_instr   = if_instr_q;
  assign if_imm     = if_imm_q;
  assign if_pc_next = if_pc_next_q;
  assign if_valid   = if_valid_q;

  // Memory address: fixed vectors while vectoring, otherwise the PC.
  always_comb begin
    imem_addr = pc_q;
    case (state_q)
      ST_RST_VEC:  imem_addr = RESET_VEC_ADDR;
      ST_INTR_VEC: imem_addr = INTR_VEC_ADDR;
      default:     imem_addr = pc_q;
    endcase
  end

  // Next-state and issue logic: redirect beats stall, stall freezes everything.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    op_hold_d    = op_hold_q;
    if_instr_d   = if_instr_q;
    if_imm_d     = if_imm_q;
    if_pc_next_d = if_pc_next_q;
    if_valid_d   = if_valid_q;
`ifdef FETCH_INTR_EN
    if_intr_d    = 1'b0;
    intr_enter   = 1'b0;
`endif
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      state_d    = ST_FETCH_OP;
      if_valid_d = 1'b0;
      op_hold_d  = 8'h00;
    end else if (!stall) begin
      if_valid_d = 1'b0;
      case (state_q)
        ST_RST_VEC, ST_INTR_VEC: begin
          pc_d    = imem_rdata;
          state_d = ST_FETCH_OP;
        end
        ST_FETCH_OP: begin
          if (intr_pending_eff) begin
            if_instr_d   = 8'h00;
            if_imm_d     = 8'h00;
            if_pc_next_d = pc_q;
            if_valid_d   = 1'b1;
            state_d      = ST_INTR_VEC;
`ifdef FETCH_INTR_EN
            if_intr_d    = 1'b1;
            intr_enter   = 1'b1;
`endif
          end else if (imem_rdata[7:4] == OPC_TWO_BYTE) begin
            op_hold_d = imem_rdata;
            pc_d      = pc_inc;
            state_d   = ST_FETCH_IMM;
          end else begin
            if_instr_d   = imem_rdata;
            if_imm_d     = 8'h00;
            if_pc_next_d = pc_inc;
            if_valid_d   = 1'b1;
            pc_d         = pc_inc;
          end
        end
        ST_FETCH_IMM: begin
          if_instr_d   = op_hold_q;
          if_imm_d     = imem_rdata;
          if_pc_next_d = pc_inc;
          if_valid_d   = 1'b1;
          pc_d         = pc_inc;
          state_d      = ST_FETCH_OP;
        end
        default: state_d = ST_RST_VEC;
      endcase
    end
`ifdef FETCH_INTR_EN
    intr_pending_d = intr_enter ? 1'b0 : intr_pending_eff;
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RST_VEC;
      pc_q         <= 8'h00;
      op_hold_q    <= 8'h00;
      if_instr_q   <= 8'h00;
      if_imm_q     <= 8'h00;
      if_pc_next_q <= 8'h00;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      op_hold_q    <= op_hold_d;
      if_instr_q   <= if_instr_d;
      if_imm_q     <= if_imm_d;
      if_pc_next_q <= if_pc_next_d;
      if_valid_q   <= if_valid_d;
    end
  end

`ifdef FETCH_INTR_EN
  // Interrupt bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      intr_pending_q <= 1'b0;
      if_intr_q      <= 1'b0;
    end else begin
      intr_pending_q <= intr_pending_d;
      if_intr_q      <= if_intr_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios with literal expectations plus
// an instruction-stream model compared against the DUT on every cycle.
module tb_fetch_unit;

  logic       clk;
  logic       rst;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       stall;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       intr_req;
  logic [7:0] if_instr;
  logic [7:0] if_imm;
  logic [7:0] if_pc_next;
  logic       if_valid;
  logic       if_intr;

  logic [7:0] mem [0:255];
  int         vectors;
  int         miscompares;
  bit         chk_en;

  // Model of the instruction stream seen by the decoder.
  bit         m_boot;
  bit         m_vec;
  bit         m_half;
  bit         m_pend;
  int         m_pc;
  logic [7:0] m_op;
  logic [7:0] m_byte;
  logic [7:0] e_instr;
  logic [7:0] e_imm;
  logic [7:0] e_pcn;
  bit         e_valid;
  bit         e_intr;

  assign imem_rdata = mem[imem_addr];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .intr_req       (intr_req),
    .if_instr       (if_instr),
    .if_imm         (if_imm),
    .if_pc_next     (if_pc_next),
    .if_valid       (if_valid),
    .if_intr        (if_intr)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %02h required %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_addr();
    if (m_boot) return 8'h00;
    if (m_vec)  return 8'h01;
    return 8'(m_pc);
  endfunction

  // Model update: decide what the decoder receives for this cycle's inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_boot = 1; m_vec = 0; m_half = 0; m_pend = 0; m_pc = 0; m_op = 8'h00;
      e_instr = 8'h00; e_imm = 8'h00; e_pcn = 8'h00; e_valid = 0; e_intr = 0;
    end else begin
      m_byte = mem[model_addr()];
`ifdef FETCH_INTR_EN
      if (intr_req) m_pend = 1;
`endif
      e_intr = 0;
      if (redirect_valid) begin
        m_pc = int'(redirect_pc); m_boot = 0; m_vec = 0; m_half = 0; e_valid = 0;
      end else if (!stall) begin
        e_valid = 0;
        if (m_boot || m_vec) begin
          m_pc = int'(m_byte); m_boot = 0; m_vec = 0;
        end else if (m_half) begin
          e_instr = m_op; e_imm = m_byte; e_pcn = 8'((m_pc + 1) % 256);
          e_valid = 1; m_pc = (m_pc + 1) % 256; m_half = 0;
        end else if (m_pend) begin
          e_instr = 8'h00; e_pcn = 8'(m_pc); e_valid = 1; e_intr = 1;
          m_vec = 1; m_pend = 0;
        end else if (m_byte >= 8'hC0 && m_byte <= 8'hCF) begin
          m_op = m_byte; m_half = 1; m_pc = (m_pc + 1) % 256;
        end else begin
          e_instr = m_byte; e_imm = 8'h00; e_pcn = 8'((m_pc + 1) % 256);
          e_valid = 1; m_pc = (m_pc + 1) % 256;
        end
      end
    end
  end

  // Compare process: DUT against the model on the falling edge of every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check_output("model imem_addr", imem_addr, model_addr());
      check_output("model if_valid", {7'd0, if_valid}, {7'd0, e_valid});
      check_output("model if_intr", {7'd0, if_intr}, {7'd0, e_intr});
      if (e_valid) begin
        check_output("model if_instr", if_instr, e_instr);
        check_output("model if_pc_next", if_pc_next, e_pcn);
        if (!e_intr) check_output("model if_imm", if_imm, e_imm);
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic rv,
                                input logic [7:0] rp, input logic ir);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp; intr_req = ir;
  endtask

  task automatic do_reset(input logic [7:0] start);
    mem[0] = start;
    apply_stimulus(1, 0, 0, 8'h00, 0);
    next_cycle();
    next_cycle();
    apply_stimulus(0, 0, 0, 8'h00, 0);
    next_cycle();
  endtask

  logic [7:0] exp_instr [0:2];
  logic [7:0] exp_pcn   [0:2];

  initial begin
    vectors = 0; miscompares = 0; chk_en = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    exp_instr[0] = 8'h21; exp_instr[1] = 8'h00; exp_instr[2] = 8'h32;
    exp_pcn[0]   = 8'h11; exp_pcn[1]   = 8'h12; exp_pcn[2]   = 8'h13;

    // Reset state and straight-line one-byte fetch.
    mem[0] = 8'h10; mem[8'h10] = 8'h21; mem[8'h11] = 8'h00; mem[8'h12] = 8'h32;
    apply_stimulus(1, 0, 0, 8'h00, 0);
    next_cycle();
    chk_en = 1;
    check_output("reset if_valid", {7'd0, if_valid}, 8'h00);
    check_output("reset if_instr", if_instr, 8'h00);
    check_output("reset if_pc_next", if_pc_next, 8'h00);
    check_output("reset imem_addr", imem_addr, 8'h00);
    next_cycle();
    apply_stimulus(0, 0, 0, 8'h00, 0);
    next_cycle();
    check_output("vector if_valid", {7'd0, if_valid}, 8'h00);
    check_output("vector imem_addr", imem_addr, 8'h10);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check_output("seq if_valid", {7'd0, if_valid}, 8'h01);
      check_output("seq if_instr", if_instr, exp_instr[k]);
      check_output("seq if_pc_next", if_pc_next, exp_pcn[k]);
    end

    // Two-byte instruction: one bubble then the pair.
    mem[8'h10] = 8'hC1; mem[8'h11] = 8'h40; mem[8'h12] = 8'h00;
    do_reset(8'h10);
    next_cycle();
    check_output("bubble if_valid", {7'd0, if_valid}, 8'h00);
    next_cycle();
    check_output("two-byte if_instr", if_instr, 8'hC1);
    check_output("two-byte if_imm", if_imm, 8'h40);
    check_output("two-byte if_pc_next", if_pc_next, 8'h12);

    // Stall for three cycles in the middle of a two-byte fetch.
    mem[8'h12] = 8'hC2; mem[8'h13] = 8'h77;
    next_cycle();
    apply_stimulus(0, 1, 0, 8'h00, 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check_output("stall imem_addr", imem_addr, 8'h13);
      check_output("stall if_instr", if_instr, 8'hC1);
      check_output("stall if_valid", {7'd0, if_valid}, 8'h00);
    end
    apply_stimulus(0, 0, 0, 8'h00, 0);
    next_cycle();
    check_output("resume if_instr", if_instr, 8'hC2);
    check_output("resume if_imm", if_imm, 8'h77);
    check_output("resume if_pc_next", if_pc_next, 8'h14);

    // Redirect while stalled in the immediate phase.
    mem[8'h14] = 8'hC3; mem[8'h15] = 8'h11; mem[8'h80] = 8'h5A;
    next_cycle();
    apply_stimulus(0, 1, 1, 8'h80, 0);
    next_cycle();
    check_output("redirect if_valid", {7'd0, if_valid}, 8'h00);
    check_output("redirect imem_addr", imem_addr, 8'h80);
    apply_stimulus(0, 0, 0, 8'h00, 0);
    next_cycle();
    check_output("target if_instr", if_instr, 8'h5A);
    check_output("target if_pc_next", if_pc_next, 8'h81);

    // Two-byte instruction straddling the top of the address space.
    mem[8'hFF] = 8'hC0; mem[0] = 8'h55;
    apply_stimulus(0, 0, 1, 8'hFF, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 8'h00, 0);
    next_cycle();
    check_output("wrap imem_addr", imem_addr, 8'h00);
    next_cycle();
    check_output("wrap if_instr", if_instr, 8'hC0);
    check_output("wrap if_imm", if_imm, 8'h55);
    check_output("wrap if_pc_next", if_pc_next, 8'h01);

    // Reset in the middle of a two-byte fetch, with stall also high.
    mem[8'h01] = 8'hC5;
    next_cycle();
    apply_stimulus(1, 1, 0, 8'h00, 1);
    next_cycle();
    check_output("midreset if_valid", {7'd0, if_valid}, 8'h00);
    check_output("midreset if_instr", if_instr, 8'h00);
    check_output("midreset if_imm", if_imm, 8'h00);
    check_output("midreset imem_addr", imem_addr, 8'h00);
    apply_stimulus(0, 0, 0, 8'h00, 0);

`ifdef FETCH_INTR_EN
    // Interrupt at a boundary, then one deferred past a two-byte instruction.
    mem[8'h01] = 8'hA0; mem[8'hA0] = 8'h00; mem[8'h14] = 8'h00;
    apply_stimulus(0, 0, 1, 8'h14, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 8'h00, 1);
    next_cycle();
    check_output("intr if_intr", {7'd0, if_intr}, 8'h01);
    check_output("intr if_valid", {7'd0, if_valid}, 8'h01);
    check_output("intr if_pc_next", if_pc_next, 8'h14);
    apply_stimulus(0, 0, 0, 8'h00, 0);
    next_cycle();
    check_output("intr vec if_intr", {7'd0, if_intr}, 8'h00);
    check_output("intr vec imem_addr", imem_addr, 8'hA0);
    next_cycle();
    check_output("handler if_pc_next", if_pc_next, 8'hA1);
    mem[8'h30] = 8'hC4; mem[8'h31] = 8'h99; mem[8'h32] = 8'h00;
    apply_stimulus(0, 0, 1, 8'h30, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 8'h00, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 8'h00, 1);
    next_cycle();
    check_output("defer if_intr", {7'd0, if_intr}, 8'h00);
    check_output("defer if_instr", if_instr, 8'hC4);
    check_output("defer if_imm", if_imm, 8'h99);
    apply_stimulus(0, 0, 0, 8'h00, 0);
    next_cycle();
    check_output("deferred if_intr", {7'd0, if_intr}, 8'h01);
    check_output("deferred if_pc_next", if_pc_next, 8'h32);
`else
    // Interrupt request must have no effect in this build.
    mem[8'h14] = 8'h00;
    apply_stimulus(0, 0, 1, 8'h14, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 8'h00, 1);
    next_cycle();
    check_output("nointr if_intr", {7'd0, if_intr}, 8'h00);
    check_output("nointr if_pc_next", if_pc_next, 8'h15);
    apply_stimulus(0, 0, 0, 8'h00, 0);
`endif

    for (int k = 0; k < 4; k++) next_cycle();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
